// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: FSM states,
// 2-bit saturating counter encodings and the counter update helper.
package bp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// synchronous train/allocate port that read-modify-writes the indexed entry.
module bp_table
    import bp_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_hit,
    output logic [1:0]      rd_cnt,
    output logic [PC_W-1:0] rd_target,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic [PC_W-1:0] wr_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    logic            valid_reg [ENTRIES];
    logic [1:0]      cnt_reg   [ENTRIES];
    logic [TAG_W-1:0] tag_mem  [ENTRIES];
    logic [PC_W-1:0] target_mem [ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;
    logic             unused_pc_bits;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[PC_W-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_hit    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_cnt    = cnt_reg[rd_idx];
    assign rd_target = target_mem[rd_idx];
    assign wr_hit    = valid_reg[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
                cnt_reg[i]   <= CNT_RESET;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                cnt_reg[wr_idx] <= cnt_update(cnt_reg[wr_idx], wr_taken);
            end else if (wr_taken) begin
                valid_reg[wr_idx] <= 1'b1;
                cnt_reg[wr_idx]   <= CNT_WT;
            end
        end
    end

    // Tag and target only change on taken outcomes; a not-taken miss writes nothing.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor and redirect controller. Optional performance
// counters are built when BP_PERF_EN is defined; otherwise they read as zero.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_branch,
    input  logic            ex_jalr,
    input  logic            ex_pcsel,
    input  logic [31:0]     ex_brpc,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            flush,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);
    logic            lookup_hit;
    logic [1:0]      lookup_cnt;
    logic [PC_W-1:0] lookup_target;
    logic            evaluate, mispredict, train;
    logic [31:0]     correct_pc;
    bp_state_t       state_reg, state_next;
    logic [31:0]     redirect_pc_reg, redirect_pc_next;

    bp_table #(.PC_W(PC_W), .ENTRIES(BTB_ENTRIES)) u_table (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (if_pc),
        .rd_hit    (lookup_hit),
        .rd_cnt    (lookup_cnt),
        .rd_target (lookup_target),
        .wr_en     (train),
        .wr_pc     (ex_pc),
        .wr_taken  (ex_pcsel),
        .wr_target (ex_brpc[PC_W-1:0])
    );

    assign pred_taken  = lookup_hit && lookup_cnt[1];
    assign pred_target = lookup_hit ? {{(32-PC_W){1'b0}}, lookup_target} : 32'd0;

    // The instruction in EX during FLUSH is on the wrong path, so nothing is evaluated.
    assign evaluate   = (state_reg == IDLE) && ex_valid && !ex_stall;
    assign mispredict = (ex_pcsel != ex_pred_taken) || (ex_pcsel && (ex_brpc != ex_pred_target));
    assign correct_pc = ex_pcsel ? ex_brpc : {{(32-PC_W){1'b0}}, ex_pc} + 32'd4;
    assign train      = evaluate && ex_branch && !ex_jalr;

    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        case (state_reg)
            IDLE: begin
                if (evaluate && mispredict) begin
                    state_next       = FLUSH;
                    redirect_pc_next = correct_pc;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            redirect_pc_reg <= 32'd0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    assign redirect    = (state_reg == FLUSH);
    assign flush       = (state_reg == FLUSH);
    assign redirect_pc = redirect_pc_reg;

`ifdef BP_PERF_EN
    logic [31:0] perf_branches_reg, perf_mispredicts_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches_reg    <= 32'd0;
            perf_mispredicts_reg <= 32'd0;
        end else begin
            if (evaluate && (ex_branch || ex_jalr) && (perf_branches_reg != 32'hFFFF_FFFF))
                perf_branches_reg <= perf_branches_reg + 32'd1;
            if (evaluate && mispredict && (perf_mispredicts_reg != 32'hFFFF_FFFF))
                perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
        end
    end

    assign perf_branches    = perf_branches_reg;
    assign perf_mispredicts = perf_mispredicts_reg;
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table, an
// asynchronous-reset-in-FLUSH sequence, then random traffic against a model.
module tb_branch_predict_ctrl;
    localparam int PC_W    = 9;
    localparam int ENTRIES = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] if_pc, ex_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            ex_valid, ex_stall, ex_branch, ex_jalr, ex_pcsel, ex_pred_taken;
    logic [31:0]     ex_brpc, ex_pred_target;
    logic            redirect, flush;
    logic [31:0]     redirect_pc, perf_branches, perf_mispredicts;

    branch_predict_ctrl #(.PC_W(PC_W), .BTB_ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_pc            (ex_pc),
        .ex_branch        (ex_branch),
        .ex_jalr          (ex_jalr),
        .ex_pcsel         (ex_pcsel),
        .ex_brpc          (ex_brpc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_perf(input int unsigned v);
`ifdef BP_PERF_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Behavioural model: the table as plain integer arrays.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    bit          m_flush;
    logic [31:0] m_rpc;
    int unsigned m_nbr, m_nmis;

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input int unsigned pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input int unsigned pc);
        return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
        end
        m_flush = 1'b0;
        m_rpc   = 32'd0;
        m_nbr   = 0;
        m_nmis  = 0;
    endtask

    task automatic model_step();
        int unsigned pc, i;
        bit mis;
        pc = int'(ex_pc);
        i  = idx_of(pc);
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (ex_valid && !ex_stall) begin
            mis = (ex_pcsel != ex_pred_taken) || (ex_pcsel && ex_brpc != ex_pred_target);
            if (ex_branch || ex_jalr) m_nbr++;
            if (mis) begin
                m_nmis++;
                m_flush = 1'b1;
                m_rpc   = ex_pcsel ? ex_brpc : pc + 4;
            end
            if (ex_branch && !ex_jalr) begin
                if (m_hit(pc)) begin
                    if (ex_pcsel) begin
                        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                        m_tgt[i] = ex_brpc % (1 << PC_W);
                    end else begin
                        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    end
                end else if (ex_pcsel) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(pc);
                    m_tgt[i]   = ex_brpc % (1 << PC_W);
                    m_cnt[i]   = 2;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, then advances.
    task automatic model_cycle();
        #4;
        chk("rnd_pred_taken", pred_taken, m_pred_taken(int'(if_pc)));
        chk("rnd_pred_target", pred_target, m_pred_target(int'(if_pc)));
        chk("rnd_redirect", redirect, m_flush);
        chk("rnd_flush", flush, m_flush);
        if (m_flush) chk("rnd_redirect_pc", redirect_pc, m_rpc);
        chk("rnd_perf_branches", perf_branches, exp_perf(m_nbr));
        chk("rnd_perf_mispredicts", perf_mispredicts, exp_perf(m_nmis));
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [8:0]  if_pc;
        logic        ev, stall, br, jalr, pcsel;
        logic [8:0]  pc;
        logic [31:0] brpc;
        logic        ptk;
        logic [31:0] ptg;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    function automatic vec_t mk(input logic [8:0] ipc, input logic ev, stall, br, jalr, pcsel,
                                input logic [8:0] pc, input logic [31:0] brpc,
                                input logic ptk, input logic [31:0] ptg,
                                input logic e_pt, input logic [31:0] e_ptg,
                                input logic e_redir, input logic [31:0] e_rpc);
        vec_t v;
        v.if_pc = ipc; v.ev = ev; v.stall = stall; v.br = br; v.jalr = jalr; v.pcsel = pcsel;
        v.pc = pc; v.brpc = brpc; v.ptk = ptk; v.ptg = ptg;
        v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_redir = e_redir; v.e_rpc = e_rpc;
        return v;
    endfunction

    vec_t vecs [17];
    int unsigned pool [12];

    initial begin
        //               if_pc   ev st br jr ps  pc     brpc         ptk ptg     e_pt e_ptg  redir rpc
        vecs[0]  = mk(9'h010, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[1]  = mk(9'h010, 1, 0, 1, 0, 1, 9'h010, 32'h080,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[2]  = mk(9'h010, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   1, 32'h080, 1, 32'h080);
        vecs[3]  = mk(9'h010, 1, 0, 1, 0, 0, 9'h010, 32'h0,     1, 32'h080, 1, 32'h080, 0, 32'h0);
        vecs[4]  = mk(9'h010, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   0, 32'h080, 1, 32'h014);
        vecs[5]  = mk(9'h010, 1, 0, 1, 0, 0, 9'h010, 32'h0,     0, 32'h0,   0, 32'h080, 0, 32'h0);
        vecs[6]  = mk(9'h010, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   0, 32'h080, 0, 32'h0);
        vecs[7]  = mk(9'h050, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[8]  = mk(9'h020, 1, 0, 0, 1, 1, 9'h020, 32'h1234,  0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[9]  = mk(9'h020, 1, 0, 1, 0, 1, 9'h030, 32'h0C0,   0, 32'h0,   0, 32'h0,   1, 32'h1234);
        vecs[10] = mk(9'h030, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[11] = mk(9'h040, 1, 1, 1, 0, 1, 9'h040, 32'h100,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[12] = mk(9'h040, 1, 1, 1, 0, 1, 9'h040, 32'h100,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[13] = mk(9'h040, 1, 1, 1, 0, 1, 9'h040, 32'h100,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[14] = mk(9'h040, 1, 0, 1, 0, 1, 9'h040, 32'h100,   0, 32'h0,   0, 32'h0,   0, 32'h0);
        vecs[15] = mk(9'h040, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   1, 32'h100, 1, 32'h100);
        vecs[16] = mk(9'h040, 0, 0, 0, 0, 0, 9'h000, 32'h0,     0, 32'h0,   1, 32'h100, 0, 32'h0);

        reset = 1'b1;
        if_pc = '0; ex_pc = '0; ex_valid = 0; ex_stall = 0; ex_branch = 0; ex_jalr = 0;
        ex_pcsel = 0; ex_brpc = '0; ex_pred_taken = 0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_perf_branches", perf_branches, 32'd0);
        chk("reset_perf_mispredicts", perf_mispredicts, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);

        for (int k = 0; k < 17; k++) begin
            if_pc = vecs[k].if_pc; ex_valid = vecs[k].ev; ex_stall = vecs[k].stall;
            ex_branch = vecs[k].br; ex_jalr = vecs[k].jalr; ex_pcsel = vecs[k].pcsel;
            ex_pc = vecs[k].pc; ex_brpc = vecs[k].brpc;
            ex_pred_taken = vecs[k].ptk; ex_pred_target = vecs[k].ptg;
            #4;
            $display("vec %0d: if_pc=0x%0h pred=%0b/0x%0h redirect=%0b rpc=0x%0h", k, if_pc,
                     pred_taken, pred_target, redirect, redirect_pc);
            chk($sformatf("vec%0d_pred_taken", k), pred_taken, vecs[k].e_pt);
            chk($sformatf("vec%0d_pred_target", k), pred_target, vecs[k].e_ptg);
            chk($sformatf("vec%0d_redirect", k), redirect, vecs[k].e_redir);
            chk($sformatf("vec%0d_flush", k), flush, vecs[k].e_redir);
            if (vecs[k].e_redir) chk($sformatf("vec%0d_redirect_pc", k), redirect_pc, vecs[k].e_rpc);
            @(posedge clk);
            #1;
        end
        chk("vec_perf_branches", perf_branches, exp_perf(5));
        chk("vec_perf_mispredicts", perf_mispredicts, exp_perf(4));

        // Reset asserted mid-FLUSH: outputs drop at once and the redirect never returns.
        if_pc = 9'h0F0; ex_valid = 1; ex_branch = 1; ex_jalr = 0; ex_pcsel = 1; ex_stall = 0;
        ex_pc = 9'h0F0; ex_brpc = 32'h0A0; ex_pred_taken = 0; ex_pred_target = 32'h0;
        @(posedge clk);
        #1 ex_valid = 0;
        #1;
        chk("arst_pre_redirect", redirect, 1'b1);
        chk("arst_pre_pred_taken", pred_taken, 1'b1);
        reset = 1'b1;
        #1;
        $display("async reset in flush: redirect=%0b flush=%0b pred_taken=%0b", redirect, flush, pred_taken);
        chk("arst_redirect", redirect, 1'b0);
        chk("arst_flush", flush, 1'b0);
        chk("arst_pred_taken", pred_taken, 1'b0);
        chk("arst_perf_branches", perf_branches, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #4 chk("arst_after_redirect", redirect, 1'b0);
        @(posedge clk);
        #1 chk("arst_after2_redirect", redirect, 1'b0);

        model_reset();
        for (int i = 0; i < 12; i++) pool[i] = $urandom_range(0, 127) * 4;
        for (int c = 0; c < 2000; c++) begin
            int unsigned kind;
            kind      = $urandom_range(0, 9);
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_stall  = ($urandom_range(0, 5) == 0);
            ex_pc     = 9'(pool[$urandom_range(0, 11)]);
            if_pc     = 9'(pool[$urandom_range(0, 11)]);
            ex_branch = (kind < 6);
            ex_jalr   = (kind == 6) || (kind == 7);
            ex_pcsel  = (kind < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            ex_brpc   = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 3) != 0) begin
                ex_pred_taken  = m_pred_taken(int'(ex_pc));
                ex_pred_target = m_pred_target(int'(ex_pc));
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                ex_pred_target = pool[$urandom_range(0, 11)];
            end
            model_cycle();
        end
        $display("random: %0d branches, %0d mispredicts modelled", m_nbr, m_nmis);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
